pc_fetch_sequencer: RTL

//  Controller for the program counter: drives its load/output-enable/increment strobes and sequences

---
 rtl/pc_seq_pkg.sv | 18 +
 rtl/fetch_wdt.sv | 28 ++
 rtl/pc_fetch_sequencer.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/pc_seq_pkg.sv
// Shared types and defaults for the PC fetch sequencer: FSM state encoding, bus widths, vectors.
package pc_seq_pkg;

    localparam int          ADDR_W_DEF    = 15;
    localparam int          DATA_W_DEF    = 16;
    localparam logic [14:0] RESET_VEC_DEF = 15'h0000;
    localparam logic [14:0] TRAP_VEC_DEF  = 15'h7FF0;
    localparam int          WDT_LIMIT_DEF = 64;

    typedef enum logic [2:0] {
        ST_LOAD_VEC,
        ST_ADDR,
        ST_ISSUE,
        ST_ADV,
        ST_HALT
    } state_t;

endpackage

// File: rtl/fetch_wdt.sv
// Fetch watchdog: counts consecutive cycles with run_i high; expired_o flags the LIMIT-th cycle.
// Combinational expiry, no backpressure; counter clears whenever run_i drops or on expiry.
module fetch_wdt #(
    parameter int LIMIT = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic run_i,
    output logic expired_o
);

    localparam int CW = $clog2(LIMIT + 1);

    logic [CW-1:0] cnt_q;

    assign expired_o = run_i && (cnt_q == CW'(LIMIT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (run_i && !expired_o) begin
            cnt_q <= cnt_q + CW'(1);
        end else begin
            cnt_q <= '0;
        end
    end

endmodule

// File: rtl/pc_fetch_sequencer.sv
// PC strobe controller and fetch sequencer: 3 cycles/instr at zero wait; ADDR stalls on mem_ack, ISSUE on instr_ready.
// FETCH_WDT_EN adds a fetch timeout that aborts to TRAP_VEC; without it ADDR waits indefinitely.
module pc_fetch_sequencer
    import pc_seq_pkg::*;
#(
    parameter int                ADDR_W    = ADDR_W_DEF,
    parameter int                DATA_W    = DATA_W_DEF,
    parameter logic [ADDR_W-1:0] RESET_VEC = ADDR_W'(RESET_VEC_DEF)
`ifdef FETCH_WDT_EN
    ,
    parameter logic [ADDR_W-1:0] TRAP_VEC  = ADDR_W'(TRAP_VEC_DEF),
    parameter int                WDT_LIMIT = WDT_LIMIT_DEF
`endif
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] pc_in,
    input  logic [ADDR_W-1:0] pc_out,
    output logic              pc_re,
    output logic              pc_we,
    output logic              pc_inc,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [DATA_W-1:0] instr_data,
    output logic [ADDR_W-1:0] instr_addr,
    input  logic              br_valid,
    input  logic [ADDR_W-1:0] br_target,
    output logic              br_ack,
    input  logic              halt,
    output logic              halted,
    output logic              fetch_fault
);

    state_t            state_q;
    logic              pc_re_q, pc_we_q, pc_inc_q, mem_req_q;
    logic              instr_valid_q, br_ack_q, halted_q;
    logic [ADDR_W-1:0] pc_in_q, instr_addr_q;
    logic [DATA_W-1:0] instr_data_q;

    // Strobes for the upcoming ADV cycle, decided as the FSM enters it.
    logic adv_re_d, adv_inc_d;
    assign adv_re_d  = br_valid;
    assign adv_inc_d = !br_valid && !halt;

`ifdef FETCH_WDT_EN
    logic wdt_expired;
    logic fetch_fault_q;

    fetch_wdt #(.LIMIT(WDT_LIMIT)) u_fetch_wdt (
        .clk       (clk),
        .rst       (rst),
        .run_i     (state_q == ST_ADDR),
        .expired_o (wdt_expired)
    );

    assign fetch_fault = fetch_fault_q;
`else
    assign fetch_fault = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_LOAD_VEC;
            pc_re_q       <= 1'b0;
            pc_we_q       <= 1'b0;
            pc_inc_q      <= 1'b0;
            mem_req_q     <= 1'b0;
            instr_valid_q <= 1'b0;
            br_ack_q      <= 1'b0;
            halted_q      <= 1'b0;
            pc_in_q       <= '0;
            instr_addr_q  <= '0;
            instr_data_q  <= '0;
`ifdef FETCH_WDT_EN
            fetch_fault_q <= 1'b0;
`endif
        end else begin
            br_ack_q <= 1'b0;
`ifdef FETCH_WDT_EN
            fetch_fault_q <= 1'b0;
`endif
            case (state_q)
                // Coming out of reset pc_re is still low, so spend one cycle raising it.
                ST_LOAD_VEC: begin
                    if (!pc_re_q) begin
                        pc_re_q <= 1'b1;
                        pc_in_q <= RESET_VEC;
                    end else begin
                        pc_re_q   <= 1'b0;
                        pc_we_q   <= 1'b1;
                        mem_req_q <= 1'b1;
                        state_q   <= ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    if (mem_ack) begin
                        instr_data_q  <= mem_rdata;
                        instr_addr_q  <= pc_out;
                        instr_valid_q <= 1'b1;
                        pc_we_q       <= 1'b0;
                        mem_req_q     <= 1'b0;
                        state_q       <= ST_ISSUE;
                    end
`ifdef FETCH_WDT_EN
                    else if (wdt_expired) begin
                        pc_we_q       <= 1'b0;
                        mem_req_q     <= 1'b0;
                        fetch_fault_q <= 1'b1;
                        pc_re_q       <= 1'b1;
                        pc_in_q       <= TRAP_VEC;
                        state_q       <= ST_LOAD_VEC;
                    end
`endif
                end
                ST_ISSUE: begin
                    if (instr_ready) begin
                        instr_valid_q <= 1'b0;
                        pc_re_q       <= adv_re_d;
                        br_ack_q      <= adv_re_d;
                        pc_inc_q      <= adv_inc_d;
                        if (adv_re_d) pc_in_q <= br_target;
                        state_q       <= ST_ADV;
                    end
                end
                ST_ADV: begin
                    pc_re_q  <= 1'b0;
                    pc_inc_q <= 1'b0;
                    if (pc_re_q || pc_inc_q) begin
                        pc_we_q   <= 1'b1;
                        mem_req_q <= 1'b1;
                        state_q   <= ST_ADDR;
                    end else begin
                        halted_q <= 1'b1;
                        state_q  <= ST_HALT;
                    end
                end
                ST_HALT: begin
                    if (!halt) begin
                        halted_q <= 1'b0;
                        pc_re_q  <= adv_re_d;
                        br_ack_q <= adv_re_d;
                        pc_inc_q <= adv_inc_d;
                        if (adv_re_d) pc_in_q <= br_target;
                        state_q  <= ST_ADV;
                    end
                end
                default: state_q <= ST_LOAD_VEC;
            endcase
        end
    end

    assign pc_in       = pc_in_q;
    assign pc_re       = pc_re_q;
    assign pc_we       = pc_we_q;
    assign pc_inc      = pc_inc_q;
    assign mem_req     = mem_req_q;
    assign mem_addr    = mem_req_q ? pc_out : '0;
    assign instr_valid = instr_valid_q;
    assign instr_data  = instr_data_q;
    assign instr_addr  = instr_addr_q;
    assign br_ack      = br_ack_q;
    assign halted      = halted_q;

endmodule
